// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built around a single full_adder cell.
// Operands are consumed LSB-first from two shift registers; the carry loop
// is closed through a flip-flop. Result appears WIDTH cycles after accept.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN, which
// adds the i_sub port (B inverted, carry forced to 1 at accept).

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_psum;
  logic [WIDTH-1:0] r_sum;
  logic [CntW-1:0]  r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_load_b;
  logic             w_load_c;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as a + ~b + 1; cin is ignored in this mode.
  assign w_load_b = i_sub ? ~i_b : i_b;
  assign w_load_c = i_sub | i_cin;
`else
  assign w_load_b = i_b;
  assign w_load_c = i_cin;
`endif

  full_adder u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  // Control FSM and datapath: accept, shift one bit per cycle, publish result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= w_load_b;
            r_carry <= w_load_c;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StShift;
          end else begin
            r_state <= StIdle;
          end
        end
        StShift: begin
          r_carry <= w_fa_cout;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_psum  <= {w_fa_sum, r_psum[WIDTH-1:1]};
          if (r_cnt == LastCnt) begin
            // Counter holds at the last index so it never wraps.
            r_sum   <= {w_fa_sum, r_psum[WIDTH-1:1]};
            r_cout  <= w_fa_cout;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios and random
// operations at WIDTH=8, plus an exhaustive sweep at WIDTH=4.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       sub8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start8),
    .i_a     (a8),
    .i_b     (b8),
    .i_cin   (cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub   (sub8),
`endif
    .o_busy  (busy8),
    .o_done  (done8),
    .o_sum   (sum8),
    .o_cout  (cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start4),
    .i_a     (a4),
    .i_b     (b4),
    .i_cin   (cin4),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub   (1'b0),
`endif
    .o_busy  (busy4),
    .o_done  (done4),
    .o_sum   (sum4),
    .o_cout  (cout4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One 8-bit operation: accept, watch busy/hold, then check the result.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic s, input string tag);
    logic [8:0] exp;
    logic [7:0] sum_before;
    logic       cout_before;
    int         lat;
    bit         busy_bad;
    bit         hold_bad;
    if (s) exp = {1'b0, a} + {1'b0, ~b} + 9'd1;
    else   exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
    a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
    sum_before  = sum8;
    cout_before = cout8;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'b0;
    lat = 0; busy_bad = 0; hold_bad = 0;
    while (!done8 && lat < 40) begin
      if (busy8 !== 1'b1) busy_bad = 1;
      if (sum8 !== sum_before || cout8 !== cout_before) hold_bad = 1;
      tick();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd8);
    chk({tag, " busy_during"}, 64'(busy_bad), 64'd0);
    chk({tag, " result_hold"}, 64'(hold_bad), 64'd0);
    chk({tag, " sum"}, 64'(sum8), 64'(exp[7:0]));
    chk({tag, " cout"}, 64'(cout8), 64'(exp[8]));
    chk({tag, " busy_at_done"}, 64'(busy8), 64'd0);
  endtask

  initial begin
    int ndone;
    logic [7:0] sum_at_done;
    logic [4:0] exp4;

    // Reset state
    #2;
    chk("reset busy", 64'(busy8), 64'd0);
    chk("reset done", 64'(done8), 64'd0);
    chk("reset sum", 64'(sum8), 64'd0);
    chk("reset cout", 64'(cout8), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic add, then the done pulse must be one cycle wide
    op8(8'h3A, 8'h25, 1'b0, 1'b0, "add_3a_25");
    tick();
    chk("done_pulse_width", 64'(done8), 64'd0);

    // Carry out, then back-to-back start issued in the done cycle
    op8(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
    op8(8'h00, 8'h00, 1'b1, 1'b0, "b2b_cin");

    // Start while busy is ignored
    a8 = 8'h10; b8 = 8'h10; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    ndone = 0; sum_at_done = '0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin a8 = 8'hAA; start8 = 1'b1; end
      if (i == 4) start8 = 1'b0;
      tick();
      if (done8) begin
        ndone++;
        sum_at_done = sum8;
      end
    end
    chk("ignored_start done_count", 64'(ndone), 64'd1);
    chk("ignored_start sum", 64'(sum_at_done), 64'h20);

    // Reset mid-operation
    a8 = 8'h7F; b8 = 8'h7F; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("midrst busy", 64'(busy8), 64'd0);
    chk("midrst done", 64'(done8), 64'd0);
    chk("midrst sum", 64'(sum8), 64'd0);
    chk("midrst cout", 64'(cout8), 64'd0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) ndone++;
    end
    chk("midrst no_done", 64'(ndone), 64'd0);
    op8(8'h12, 8'h34, 1'b1, 1'b0, "after_reset");

`ifdef SERIAL_ADDER_SUB_EN
    op8(8'd10, 8'd3, 1'b0, 1'b1, "sub_10_3");
    op8(8'd3, 8'd10, 1'b1, 1'b1, "sub_3_10");
`endif

    // Random operations, with occasional idle gaps between them
    for (int i = 0; i < 30; i++) begin
      logic [7:0] ra, rb;
      logic rc, rs;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      op8(ra, rb, rc, rs, "random");
      repeat ($urandom_range(0, 2)) tick();
    end
    tick();

    // Exhaustive sweep at WIDTH=4, issued back-to-back
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci); start4 = 1'b1;
          exp4 = 5'(ai + bi + ci);
          tick();
          start4 = 1'b0;
          repeat (4) tick();
          chk("exh4 done", 64'(done4), 64'd1);
          chk("exh4 result", 64'({cout4, sum4}), 64'(exp4));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that sits one stage above the single-bit `full_adder` cell. It instantiates one `full_adder`, feeds it operand bits LSB-first from two shift registers, and closes the carry loop through a flip-flop. It produces a WIDTH-bit sum and a carry-out after WIDTH clock cycles. It trades latency for area in datapaths that do not need single-cycle addition.

## Interface
- `WIDTH`, default 8: operand and sum width in bits. Legal range is 2..32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request. Sampled only while `busy`=0.
- `a`  in  WIDTH  operand A. Captured on the accepting edge.
- `b`  in  WIDTH  operand B. Captured on the accepting edge.
- `cin`  in  1  carry-in. Captured on the accepting edge.
- `busy`  out  1  high while bits are being processed.
- `done`  out  1  one-cycle pulse when `sum`/`cout` update.
- `sum`  out  WIDTH  result register. Holds its value between operations.
- `cout`  out  1  final carry-out. Holds its value between operations.
- `sub`  in  1  present only with `SERIAL_ADDER_SUB_EN`. See Configuration.

## Operation
- FSM states and transitions:
  - IDLE → SHIFT on `start`=1.
  - SHIFT → DONE when bit counter = WIDTH-1.
  - DONE → SHIFT on `start`=1.
  - DONE → IDLE otherwise.
- Accept edge (state IDLE or DONE with `start`=1):
  - load shift register A ← `a` and shift register B ← `b`;
  - carry flop ← `cin`;
  - bit counter ← 0.
- Each SHIFT edge:
  - present `{carry, A[0], B[0]}` to `full_adder`;
  - carry ← fa.cout;
  - shift A and B right by one;
  - shift fa.sum into the MSB of the partial-sum register;
  - counter += 1.
- Counter width is `$clog2(WIDTH)`. It never wraps within an operation.
- Leaving SHIFT:
  - `sum` ← completed partial-sum register;
  - `cout` ← final fa.cout;
  - `done`=1 for exactly one cycle.
- `sum` and `cout` change only on the SHIFT→DONE edge. They are never visible mid-operation.
- Arithmetic is modulo 2^WIDTH. `cout` is the bit-WIDTH carry. No overflow flag.
- `start` is ignored while `busy`=1 and has no side effects.

## Timing
- Reset (asynchronous):
  - state=IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0;
  - internal shift, carry and counter registers = 0.
- The accept edge is E0. `busy`=1 from after E0 until after E_WIDTH.
- `done`=1 in the cycle after E_WIDTH. Latency from accept to `done` is WIDTH cycles.
- Back-to-back: `start`=1 during the `done` cycle is accepted. Sustained throughput is one result per WIDTH+1 cycles.
- `busy` deasserts in the same cycle that `done` asserts.
- Reset mid-operation: the operation is abandoned, outputs take reset values, and no `done` is issued.
- `a`, `b`, `cin` may change freely after E0. Only captured values are used.

## Configuration
- Macro `SERIAL_ADDER_SUB_EN`.
- Defined:
  - port `sub` exists and is captured at accept;
  - when `sub`=1, B is loaded as ~`b` and carry is loaded as 1, giving `sum` = a - b mod 2^WIDTH;
  - `cin` is ignored when `sub`=1;
  - `cout`=1 means no borrow.
- Not defined: the `sub` port and the inversion logic are absent, and the block adds only.

## Test plan
- WIDTH=8, a=8'h3A, b=8'h25, cin=0, start pulse → `done` exactly 8 cycles after the accept edge, `sum`=8'h5F, `cout`=0, `busy` high for 8 cycles.
- a=8'hFF, b=8'h01, cin=0 → `sum`=8'h00, `cout`=1. Then a=8'h00, b=8'h00, cin=1 issued in the `done` cycle → accepted back-to-back; 8 cycles later `sum`=8'h01, `cout`=0.
- Start a=8'h10, b=8'h10; pulse `start` again with a=8'hAA at cycle 3 while busy → second start ignored; result `sum`=8'h20; exactly one `done` pulse.
- Start a=8'h7F, b=8'h7F; assert `rst` at cycle 4 → `busy`/`done`/`sum`/`cout` go to 0 immediately; no `done` follows. A fresh start after reset completes correctly.
- With `SERIAL_ADDER_SUB_EN`, sub=1, a=8'd10, b=8'd3 → `sum`=8'd7, `cout`=1. With a=8'd3, b=8'd10 → `sum`=8'hF9, `cout`=0.
- Exhaustive at WIDTH=4: every a, b, cin combination (512 operations) matches {cout,sum} = a+b+cin.
